// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Function : Binary-to-BCD converter (shift-and-add-3, one bit per cycle)
//            feeding a time-multiplexed one-hot digit scanner with optional
//            leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BIN_W-1:0]      value,
  input  logic                  blank_zeros,
  output logic                  busy,
  output logic                  overflow,
  output logic [3:0]            bcd,
  output logic                  enable_segment,
  output logic [NUM_DIGITS-1:0] digit_sel
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Largest value the display can show: 10^NUM_DIGITS - 1.
  function automatic logic [63:0] max_display(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_display(NUM_DIGITS);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [SR_W-1:0]       sr_q, sr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]      digits_q, digits_d;
  logic                  overflow_q, overflow_d;
  logic                  valid_q, valid_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [3:0]            bcd_q, bcd_d;
  logic                  en_q, en_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

  logic [SR_W-1:0]       sr_adj;
  logic [SR_W-1:0]       sr_step;
  logic [63:0]           value_ext;
  logic [NUM_DIGITS-1:0] hi_zero;
  logic [NUM_DIGITS-1:0] blanked;

  // Add-3 correction on every BCD nibble before the shift.
  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
      assign sr_adj[BIN_W+4*g +: 4] = (sr_q[BIN_W+4*g +: 4] >= 4'd5) ?
                                      (sr_q[BIN_W+4*g +: 4] + 4'd3) :
                                       sr_q[BIN_W+4*g +: 4];
    end
  endgenerate
  assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];
  assign sr_step           = {sr_adj[SR_W-2:0], 1'b0};
  assign value_ext         = 64'(value);

  // Conversion FSM next-state: capture/clamp on load, step, atomic commit.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          if (value_ext > MAX_VAL) begin
            sr_d       = {{BCD_W{1'b0}}, MAX_VAL[BIN_W-1:0]};
            ovf_pend_d = 1'b1;
          end else begin
            sr_d       = {{BCD_W{1'b0}}, value};
            ovf_pend_d = 1'b0;
          end
          cnt_d   = CNT_W'(BIN_W);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        sr_d  = sr_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          digits_d   = sr_step[SR_W-1:BIN_W];
          overflow_d = ovf_pend_q;
          valid_d    = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Free-running scan divider and digit index.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Leading-zero detection: digit i is blankable when it and all above are 0.
  always_comb begin
    hi_zero = '0;
    blanked = '0;
    hi_zero[NUM_DIGITS-1] = (digits_q[BCD_W-1 -: 4] == 4'd0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      hi_zero[k] = hi_zero[k+1] && (digits_q[4*k +: 4] == 4'd0);
    end
    for (int k = 1; k < NUM_DIGITS; k++) begin
      blanked[k] = blank_zeros && hi_zero[k];
    end
  end

  // Output register: new scan index with the digit value held before this edge.
  always_comb begin
    bcd_d = digits_q[4*idx_d +: 4];
    sel_d = NUM_DIGITS'(1) << idx_d;
    en_d  = valid_q && !blanked[idx_d];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      div_q      <= '0;
      idx_q      <= '0;
      bcd_q      <= 4'd0;
      en_q       <= 1'b0;
      sel_q      <= NUM_DIGITS'(1);
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      bcd_q      <= bcd_d;
      en_q       <= en_d;
      sel_q      <= sel_d;
    end
  end

  assign busy           = (state_q == S_CONV);
  assign overflow       = overflow_q;
  assign bcd            = bcd_q;
  assign enable_segment = en_q;
  assign digit_sel      = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_ctrl
// Function : Self-checking bench for display_scan_ctrl against a cycle-level
//            arithmetic reference model (digits via divide/modulo).
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

  localparam int N  = 4;
  localparam int BW = 14;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [BW-1:0] value = '0;
  logic          blank_zeros = 1'b0;
  logic          busy;
  logic          overflow;
  logic [3:0]    bcd;
  logic          enable_segment;
  logic [N-1:0]  digit_sel;

  display_scan_ctrl #(
    .NUM_DIGITS(N),
    .BIN_W     (BW),
    .SCAN_DIV  (SD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .value         (value),
    .blank_zeros   (blank_zeros),
    .busy          (busy),
    .overflow      (overflow),
    .bcd           (bcd),
    .enable_segment(enable_segment),
    .digit_sel     (digit_sel)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int n         = 0;  // edges since reset
  int busy_left = 0;  // remaining busy cycles
  int pend      = 0;
  int pend_ovf  = 0;
  int disp      = 0;  // value currently on display
  int dvalid    = 0;
  int dovf      = 0;

  function automatic int p10(input int i);
    int r;
    r = 1;
    for (int k = 0; k < i; k++) r = r * 10;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the sampled inputs, then check.
  task automatic cycle();
    int e_sel, e_bcd, e_en, idx;
    @(posedge clk);
    if (rst) begin
      n = 0; busy_left = 0; disp = 0; dvalid = 0; dovf = 0;
      e_sel = 1; e_bcd = 0; e_en = 0;
    end else begin
      n++;
      idx   = (n / SD) % N;
      e_sel = 1 << idx;
      e_bcd = (disp / p10(idx)) % 10;
      e_en  = (dvalid != 0) && !(blank_zeros && idx > 0 && (disp / p10(idx)) == 0);
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          disp = pend; dovf = pend_ovf; dvalid = 1;
        end
      end else if (load) begin
        pend_ovf  = (int'(value) > p10(N) - 1) ? 1 : 0;
        pend      = pend_ovf ? p10(N) - 1 : int'(value);
        busy_left = BW;
      end
    end
    #1;
    chk("busy",           32'(busy),           32'(busy_left > 0));
    chk("overflow",       32'(overflow),       32'(dovf));
    chk("digit_sel",      32'(digit_sel),      32'(e_sel));
    chk("bcd",            32'(bcd),            32'(e_bcd));
    chk("enable_segment", 32'(enable_segment), 32'(e_en));
  endtask

  task automatic run(input int k);
    for (int c = 0; c < k; c++) cycle();
  endtask

  task automatic do_load(input int v);
    load  = 1'b1;
    value = BW'(v);
    cycle();
    load  = 1'b0;
  endtask

  initial begin
    // Reset and dark scan
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(18);

    // Basic conversion
    blank_zeros = 1'b0;
    do_load(1234);
    run(34);

    // Blanking behaviour
    blank_zeros = 1'b1;
    do_load(7);
    run(32);
    blank_zeros = 1'b0;
    run(16);
    blank_zeros = 1'b1;
    do_load(0);
    run(32);

    // Overflow clamp and recovery
    blank_zeros = 1'b0;
    do_load(12000);
    run(32);
    do_load(50);
    run(32);

    // Load during conversion is ignored (pulse at fifth busy cycle)
    do_load(1234);
    run(3);
    do_load(5678);
    run(30);

    // Reset mid-conversion at busy cycle 7
    do_load(9999);
    run(5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(16);
    do_load(42);
    run(32);

    // Randomized loads, blanking and stray load pulses
    for (int t = 0; t < 30; t++) begin
      blank_zeros = 1'($urandom_range(0, 1));
      do_load(int'($urandom_range(0, 16383)));
      for (int c = 0; c < int'($urandom_range(0, 24)); c++) begin
        if ($urandom_range(0, 3) == 0) begin
          do_load(int'($urandom_range(0, 16383)));
        end else begin
          cycle();
        end
      end
    end
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Sequential front end for the 16-segment digit decoder. It accepts a binary value (credit, price or countdown) and converts it to BCD with a one-bit-per-cycle shift-and-add-3 engine. It then time-multiplexes the resulting digits onto a single `bcd`/`enable_segment` pair with a one-hot digit select. It sits between the coffee-machine control FSM and the per-digit segment decoder.

## Interface
- `NUM_DIGITS`, 4: number of display digits; constraint `BIN_W <= 3*NUM_DIGITS+2`.
- `BIN_W`, 14: width of `value`.
- `SCAN_DIV`, 1000: clock cycles each digit stays selected; must be ≥ 2.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  single-cycle request to convert `value`; honoured only when `busy`=0.
- `value`  in  BIN_W  unsigned binary to display; sampled on the accepted `load`.
- `blank_zeros`  in  1  1 = suppress leading zeros; sampled live each cycle.
- `busy`  out  1  conversion in progress.
- `overflow`  out  1  last accepted `value` exceeded 10^NUM_DIGITS−1.
- `bcd`  out  4  BCD code of the currently selected digit, to the decoder.
- `enable_segment`  out  1  decoder enable for the selected digit.
- `digit_sel`  out  NUM_DIGITS  one-hot digit select; bit 0 is the least significant digit.

## Operation
- Reset values:
  - `busy`=0, `overflow`=0, `bcd`=0, `enable_segment`=0, `digit_sel`=1.
  - Digit registers all 0, scan index 0, divider 0.
  - The `valid` flag is 0: the display stays dark until the first conversion completes.
- Conversion FSM has two states, IDLE and CONV.
  - IDLE, `load`=1: capture `value`. If `value` > 10^NUM_DIGITS−1, capture 10^NUM_DIGITS−1 instead and set `ovf_pending`. Clear the shift register, load the bit counter with BIN_W, and go to CONV.
  - CONV: once per cycle, add 3 to every BCD nibble ≥5, then shift the whole {BCD, binary} register left by 1 and decrement the counter.
  - CONV, counter reaches 0: copy the BCD nibbles atomically into the digit registers, set `overflow`=`ovf_pending`, set `valid`=1, and return to IDLE.
  - `load` while in CONV is ignored: not queued, and no effect on the running conversion.
- Scanner runs continuously and independently of the conversion FSM.
  - The divider counts 0..SCAN_DIV−1. At the terminal count the scan index advances, wrapping from NUM_DIGITS−1 to 0.
- Output register, updated every cycle from the current scan index `i`:
  - `bcd` = digit[i]; `digit_sel` = 1<<i.
  - `enable_segment` = `valid` AND NOT blanked(i).
- Blanking rule: digit i is blanked when `blank_zeros`=1, i>0, and digit[i] through digit[NUM_DIGITS−1] are all 0.
  - Digit 0 is never blanked, so the value 0 shows as a single "0".
- Digit registers keep their old contents during CONV, so the display never shows a partial result.

## Timing
- Accepted `load` sampled at edge T:
  - `busy`=1 from T through T+BIN_W−1 (BIN_W cycles).
  - Digit registers and `overflow` update at edge T+BIN_W, the same edge at which `busy` falls.
  - A new `load` can be accepted at edge T+BIN_W+1.
- Output registers lag the scan index and digit registers by one cycle.
  - `bcd`, `digit_sel` and `enable_segment` therefore reflect a new result at edge T+BIN_W+1.
- `digit_sel` holds each one-hot value for exactly SCAN_DIV cycles.
- Simultaneous scan advance and result commit: the output register uses the new index and the pre-commit digit value. The new digit value appears on the next cycle.
- `rst` asserted mid-conversion: the conversion is aborted with no commit, and every output and state element returns to its reset value on that edge.

## Test plan
- Reset, SCAN_DIV=4: `digit_sel` steps 0001→0010→0100→1000→0001, 4 cycles each; `enable_segment`=0 throughout; `bcd`=0.
- `load` with `value`=1234, `blank_zeros`=0:
  - `busy` high for exactly 14 cycles.
  - Afterwards the scan yields `bcd` 4,3,2,1 on `digit_sel` 0001,0010,0100,1000, with `enable_segment`=1 and `overflow`=0.
- `value`=7, `blank_zeros`=1: digit 0 shows `bcd`=7 with `enable_segment`=1; digits 1–3 show `enable_segment`=0. Set `blank_zeros`=0: digits 1–3 show `bcd`=0 with enable=1. `value`=0: only digit 0 is enabled.
- `value`=12000: digits read 9,9,9,9 and `overflow`=1. A following load of 50 reads 0,0,5,0 (digit3→digit0) with `overflow`=0.
- Load 1234, then pulse `load` with 5678 at the fifth busy cycle: the result is still 1234 and `busy` deasserts on schedule.
- Load 9999, then assert `rst` at busy cycle 7: all outputs hold their reset values and the display is dark. A following load of 42 completes normally.
